tx_packet_builder: RTL and testbench

TX_PACKET_BUILDER -- requirements
Module: tx_packet_builder

---
 rtl/tx_packet_builder_pkg.sv | 48 ++++
 rtl/tx_packet_builder_if.sv | 17 +
 rtl/tx_packet_builder_load_sync.sv | 29 ++
 rtl/tx_packet_builder.sv | 180 ++++++++++++++++++
 tb/tb_tx_packet_builder.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_packet_builder_pkg.sv
// tx_pkg: shared definitions for the TX packet builder.
//   mode_e  - command encodings carried on the mode input
//   state_e - builder FSM states
//   pkt_w / data_w - derived port widths
//   *_off   - bit offsets of each field inside pkt_data
package tx_pkg;

  typedef enum logic [1:0] {
    MODE_CLR  = 2'b00,
    MODE_HDR  = 2'b01,
    MODE_DATA = 2'b10,
    MODE_SEND = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FULL,
    SEND
  } state_e;

  function automatic int pkt_w(int id_w, int len_w, int max_bytes);
    return 2 * id_w + len_w + 8 * max_bytes;
  endfunction

  // Operand must be wide enough for a full header or a payload byte.
  function automatic int data_w(int id_w, int len_w);
    return (2 * id_w + len_w > 8) ? 2 * id_w + len_w : 8;
  endfunction

  function automatic int len_off(int max_bytes);
    return 8 * max_bytes;
  endfunction

  function automatic int src_off(int len_w, int max_bytes);
    return len_w + 8 * max_bytes;
  endfunction

  function automatic int dest_off(int id_w, int len_w, int max_bytes);
    return id_w + len_w + 8 * max_bytes;
  endfunction

  // Payload byte 0 sits directly below the length field (MSB first).
  function automatic int byte_off(int idx, int max_bytes);
    return 8 * (max_bytes - 1 - idx);
  endfunction

endpackage

// File: rtl/tx_packet_builder_if.sv
// tx_packet_builder_if: valid/ready packet channel.
//   pkt_data  - packet {dest, src, len, payload}
//   pkt_valid - packet offered
//   pkt_ready - downstream accept
// master drives data/valid, slave drives ready.
interface tx_packet_builder_if
  import tx_pkg::*;
#(
  parameter int PKT_W = pkt_w(2, 5, 16)
);
  logic [PKT_W-1:0] pkt_data;
  logic             pkt_valid;
  logic             pkt_ready;

  modport master (output pkt_data, output pkt_valid, input pkt_ready);
  modport slave  (input pkt_data, input pkt_valid, output pkt_ready);
endinterface

// File: rtl/tx_packet_builder_load_sync.sv
// tx_load_sync: 2-flop synchroniser plus falling-edge detector for the raw
// active-low load key.
//   clk, rst - clock, asynchronous active-high reset
//   load     - raw key (idle high)
//   fall     - one-cycle pulse per falling edge; a command sampled with it
//              lands on the 3rd rising clk edge after the pin falls
module tx_load_sync (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic fall
);
  logic sync_p0, sync_p1, prev_p2;

  // Flops reset to 1 so a released key never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      prev_p2 <= 1'b1;
    end else begin
      sync_p0 <= load;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign fall = prev_p2 & ~sync_p1;
endmodule

// File: rtl/tx_packet_builder.sv
// tx_packet_builder: assembles a {dest, src, len, payload} packet from
// key-entered commands and offers it on a valid/ready channel.
//   clk, rst     - clock, asynchronous active-high reset
//   load         - raw active-low command key
//   mode, data   - command and operand
//   pkt_if       - packet channel (master side)
//   flag_status  - [1] header loaded, [0] payload complete
//   byte_cnt     - payload bytes loaded
//   err          - sticky command error
//   test_mode    - error-injection request
// Optional feature: define TX_TEST_MODE_EN so a send command latches data[0]
// into test_mode; otherwise test_mode is constant 0.
module tx_packet_builder
  import tx_pkg::*;
#(
  parameter int MAX_BYTES = 16,
  parameter int ID_W      = 2,
  parameter int LEN_W     = 5,
  localparam int DATA_W   = data_w(ID_W, LEN_W),
  localparam int PKT_W    = pkt_w(ID_W, LEN_W, MAX_BYTES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [1:0]          mode,
  input  logic [DATA_W-1:0]   data,
  tx_packet_builder_if.master pkt_if,
  output logic [1:0]          flag_status,
  output logic [LEN_W-1:0]    byte_cnt,
  output logic                err,
  output logic                test_mode
);
  localparam int LEN_OFF  = len_off(MAX_BYTES);
  localparam int SRC_OFF  = src_off(LEN_W, MAX_BYTES);
  localparam int DEST_OFF = dest_off(ID_W, LEN_W, MAX_BYTES);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

  logic cmd;

  tx_load_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .fall (cmd)
  );

  state_e           state_q, state_n;
  logic [PKT_W-1:0] pkt_q, pkt_n;
  logic             vld_q, vld_n;
  logic [1:0]       flag_q, flag_n;
  logic [LEN_W-1:0] cnt_q, cnt_n;
  logic             err_q, err_n;
`ifdef TX_TEST_MODE_EN
  logic             tm_q, tm_n;
`endif

  logic [ID_W-1:0]  hdr_dest, hdr_src;
  logic [LEN_W-1:0] hdr_len, len_clamped, cur_len;

  // Header fields occupy the operand MSBs in packet order.
  assign hdr_dest    = data[DATA_W-1 -: ID_W];
  assign hdr_src     = data[DATA_W-1-ID_W -: ID_W];
  assign hdr_len     = data[DATA_W-1-2*ID_W -: LEN_W];
  assign len_clamped = (hdr_len > MAX_LEN) ? MAX_LEN : hdr_len;
  assign cur_len     = pkt_q[LEN_OFF +: LEN_W];

  always_comb begin
    state_n = state_q;
    pkt_n   = pkt_q;
    vld_n   = vld_q;
    flag_n  = flag_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
`ifdef TX_TEST_MODE_EN
    tm_n    = tm_q;
`endif

    // Transfer first; a coincident clear below overrides it.
    if (state_q == SEND && pkt_if.pkt_ready) begin
      vld_n   = 1'b0;
      flag_n  = 2'b00;
      state_n = IDLE;
    end

    if (cmd) begin
      case (mode_e'(mode))
        MODE_CLR: begin
          state_n = IDLE;
          pkt_n   = '0;
          vld_n   = 1'b0;
          flag_n  = 2'b00;
          cnt_n   = '0;
          err_n   = 1'b0;
`ifdef TX_TEST_MODE_EN
          tm_n    = 1'b0;
`endif
        end
        MODE_HDR: begin
          if (state_q == SEND) begin
            err_n = 1'b1;
          end else begin
            pkt_n = '0;
            pkt_n[DEST_OFF +: ID_W]  = hdr_dest;
            pkt_n[SRC_OFF +: ID_W]   = hdr_src;
            pkt_n[LEN_OFF +: LEN_W]  = len_clamped;
            cnt_n = '0;
            if (hdr_len > MAX_LEN) err_n = 1'b1;
            if (len_clamped == '0) begin
              flag_n  = 2'b11;
              state_n = FULL;
            end else begin
              flag_n  = 2'b10;
              state_n = COLLECT;
            end
          end
        end
        MODE_DATA: begin
          if (state_q == COLLECT) begin
            pkt_n[byte_off(int'(cnt_q), MAX_BYTES) +: 8] = data[7:0];
            cnt_n = cnt_q + 1'b1;
            if (cnt_n == cur_len) begin
              flag_n[0] = 1'b1;
              state_n   = FULL;
            end
          end else begin
            err_n = 1'b1;
          end
        end
        MODE_SEND: begin
          if (state_q == FULL) begin
            vld_n   = 1'b1;
            state_n = SEND;
          end else begin
            err_n = 1'b1;
          end
`ifdef TX_TEST_MODE_EN
          tm_n = data[0];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      vld_q   <= 1'b0;
      flag_q  <= 2'b00;
      cnt_q   <= '0;
      err_q   <= 1'b0;
`ifdef TX_TEST_MODE_EN
      tm_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_n;
      pkt_q   <= pkt_n;
      vld_q   <= vld_n;
      flag_q  <= flag_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
`ifdef TX_TEST_MODE_EN
      tm_q    <= tm_n;
`endif
    end
  end

  assign pkt_if.pkt_data  = pkt_q;
  assign pkt_if.pkt_valid = vld_q;
  assign flag_status      = flag_q;
  assign byte_cnt         = cnt_q;
  assign err              = err_q;
`ifdef TX_TEST_MODE_EN
  assign test_mode        = tm_q;
`else
  assign test_mode        = 1'b0;
`endif

endmodule

// File: tb/tb_tx_packet_builder.sv
// Bench for tx_packet_builder: directed scenarios plus randomized commands,
// all compared against a field-level packet model.
module tb_tx_packet_builder;
  localparam int MAX_BYTES = 16;
  localparam int ID_W      = 2;
  localparam int LEN_W     = 5;
  localparam int DATA_W    = (2 * ID_W + LEN_W > 8) ? 2 * ID_W + LEN_W : 8;
  localparam int PKT_W     = 2 * ID_W + LEN_W + 8 * MAX_BYTES;

  logic              clk = 1'b0;
  logic              rst;
  logic              load;
  logic [1:0]        mode;
  logic [DATA_W-1:0] data;
  logic [1:0]        flag_status;
  logic [LEN_W-1:0]  byte_cnt;
  logic              err;
  logic              test_mode;

  tx_packet_builder_if #(.PKT_W(PKT_W)) pkt_if ();

  tx_packet_builder #(
    .MAX_BYTES (MAX_BYTES),
    .ID_W      (ID_W),
    .LEN_W     (LEN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .mode        (mode),
    .data        (data),
    .pkt_if      (pkt_if),
    .flag_status (flag_status),
    .byte_cnt    (byte_cnt),
    .err         (err),
    .test_mode   (test_mode)
  );

  always #5 clk = ~clk;

  // Reference model: packet fields and status bits.
  int         m_dest, m_src, m_len, m_cnt;
  logic [7:0] m_bytes [MAX_BYTES];
  bit         m_hdr, m_done, m_err, m_valid, m_tm;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [PKT_W-1:0] exp_pkt();
    logic [PKT_W-1:0] p;
    p = PKT_W'(m_dest);
    p = (p << ID_W) | PKT_W'(m_src);
    p = (p << LEN_W) | PKT_W'(m_len);
    for (int i = 0; i < MAX_BYTES; i++) p = (p << 8) | PKT_W'(m_bytes[i]);
    return p;
  endfunction

  task automatic model_clear();
    m_dest = 0; m_src = 0; m_len = 0; m_cnt = 0;
    for (int i = 0; i < MAX_BYTES; i++) m_bytes[i] = 8'h00;
    m_hdr = 0; m_done = 0; m_err = 0; m_valid = 0; m_tm = 0;
  endtask

  task automatic model_xfer();
    m_valid = 0; m_hdr = 0; m_done = 0;
  endtask

  task automatic model_apply(input logic [1:0] m, input logic [DATA_W-1:0] d, input bit rdy);
    bit pre_send, collecting, full;
    int raw;
    pre_send   = m_valid;
    collecting = m_hdr && !m_done && !m_valid;
    full       = m_done && !m_valid;
    case (m)
      2'b00: model_clear();
      2'b01: begin
        if (pre_send) m_err = 1;
        else begin
          m_dest = int'(d[8:7]);
          m_src  = int'(d[6:5]);
          raw    = int'(d[4:0]);
          if (raw > MAX_BYTES) begin m_len = MAX_BYTES; m_err = 1; end
          else m_len = raw;
          for (int i = 0; i < MAX_BYTES; i++) m_bytes[i] = 8'h00;
          m_cnt = 0; m_hdr = 1; m_done = (m_len == 0);
        end
      end
      2'b10: begin
        if (collecting) begin
          m_bytes[m_cnt] = d[7:0];
          m_cnt++;
          if (m_cnt == m_len) m_done = 1;
        end else m_err = 1;
      end
      default: begin
        if (full) m_valid = 1;
        else m_err = 1;
`ifdef TX_TEST_MODE_EN
        m_tm = d[0];
`endif
      end
    endcase
    if (rdy && pre_send && m != 2'b00) model_xfer();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pkt"},  pkt_if.pkt_data,  exp_pkt());
    chk({tag, ".vld"},  pkt_if.pkt_valid, m_valid);
    chk({tag, ".flag"}, flag_status,      {m_hdr, m_done});
    chk({tag, ".cnt"},  byte_cnt,         m_cnt);
    chk({tag, ".err"},  err,              m_err);
    chk({tag, ".tm"},   test_mode,        m_tm);
  endtask

  // One key press: falls at a negedge, lands on the 3rd posedge after.
  task automatic cmd(input string tag, input logic [1:0] m, input logic [DATA_W-1:0] d,
                     input bit rdy, input int low_cycles);
    @(negedge clk);
    mode = m; data = d; load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_all({tag, ".pre"});
    if (rdy) pkt_if.pkt_ready = 1'b1;
    @(posedge clk);
    model_apply(m, d, rdy);
    @(negedge clk);
    pkt_if.pkt_ready = 1'b0;
    check_all(tag);
    repeat (low_cycles) @(negedge clk);
    load = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_pkt(input string tag, input int hold);
    repeat (hold) begin
      @(negedge clk);
      check_all({tag, ".hold"});
    end
    @(negedge clk);
    pkt_if.pkt_ready = 1'b1;
    @(posedge clk);
    if (m_valid) model_xfer();
    @(negedge clk);
    pkt_if.pkt_ready = 1'b0;
    check_all(tag);
  endtask

  function automatic logic [DATA_W-1:0] hdr(input int dst, input int src, input int len);
    return {2'(dst), 2'(src), 5'(len)};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load = 1'b1; mode = 2'b00; data = '0;
    pkt_if.pkt_ready = 1'b0;
    model_clear();
    #2;
    check_all("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Basic packet: dest=2 src=1 len=3, A1 B2 C3.
    cmd("hdr3", 2'b01, hdr(2, 1, 3), 0, 0);
    cmd("d0", 2'b10, 9'h0A1, 0, 0);
    cmd("d1", 2'b10, 9'h0B2, 0, 1);
    cmd("d2", 2'b10, 9'h0C3, 0, 2);
    cmd("send3", 2'b11, 9'h000, 0, 0);
    chk("top_fields", pkt_if.pkt_data[PKT_W-1 -: 33],
        {2'b10, 2'b01, 5'b00011, 8'hA1, 8'hB2, 8'hC3});
    release_pkt("xfer3", 0);
    chk("flags_after", flag_status, 2'b00);

    // Zero-length header goes straight to full.
    cmd("hdr0", 2'b01, hdr(1, 3, 0), 0, 0);
    chk("flags_len0", flag_status, 2'b11);
    cmd("send0", 2'b11, 9'h000, 0, 0);
    release_pkt("xfer0", 1);

    // Over-long header is clamped and flags an error.
    cmd("clr", 2'b00, 9'h000, 0, 0);
    cmd("hdr20", 2'b01, hdr(3, 0, 20), 0, 0);
    chk("len_clamp", pkt_if.pkt_data[PKT_W-1-2*ID_W -: LEN_W], 5'd16);
    chk("err_clamp", err, 1'b1);
    for (int i = 0; i < MAX_BYTES; i++) cmd("fill", 2'b10, 9'(i * 17 + 3), 0, 0);
    cmd("byte17", 2'b10, 9'h0EE, 0, 0);
    chk("cnt16", byte_cnt, 5'd16);

    // Long stall in SEND with illegal commands, then abort.
    cmd("clr2", 2'b00, 9'h000, 0, 0);
    cmd("hdr1", 2'b01, hdr(0, 2, 1), 0, 0);
    cmd("d55", 2'b10, 9'h055, 0, 0);
    cmd("send1", 2'b11, 9'h000, 0, 0);
    repeat (10) begin
      @(negedge clk);
      check_all("stall");
    end
    cmd("dsend", 2'b10, 9'h0AA, 0, 0);
    cmd("hsend", 2'b01, hdr(1, 1, 2), 0, 0);
    chk("err_send", err, 1'b1);
    cmd("clr_send", 2'b00, 9'h000, 1, 0);
    chk("vld_abort", pkt_if.pkt_valid, 1'b0);
    cmd("d_idle", 2'b10, 9'h011, 0, 0);

    // Long key press yields a single command.
    cmd("clr3", 2'b00, 9'h000, 0, 0);
    cmd("hdr5", 2'b01, hdr(2, 2, 5), 0, 0);
    cmd("dlong", 2'b10, 9'h07E, 0, 50);
    check_all("after_long");
    chk("cnt_long", byte_cnt, 5'd1);

`ifdef TX_TEST_MODE_EN
    cmd("tm_on", 2'b11, 9'h001, 0, 0);
    chk("tm_set", test_mode, 1'b1);
`endif

    // Asynchronous reset mid-collect.
    @(negedge clk);
    #2 rst = 1'b1;
    #1 model_clear();
    check_all("rst_async");
    @(negedge clk);
    rst = 1'b0;

    // Randomized command stream.
    for (int it = 0; it < 80; it++) begin
      int r;
      logic [1:0] m;
      logic [DATA_W-1:0] d;
      r = int'($urandom % 10);
      if (r == 0) m = 2'b00;
      else if (r < 3) m = 2'b01;
      else if (r < 8) m = 2'b10;
      else m = 2'b11;
      if (m == 2'b01)
        d = hdr(int'($urandom % 4), int'($urandom % 4),
                ($urandom % 4 == 0) ? int'($urandom % 32) : int'($urandom % 6));
      else d = DATA_W'($urandom);
      cmd("rnd", m, d, ($urandom % 4) == 0, int'($urandom % 4));
      if (m_valid && ($urandom % 2) == 1) release_pkt("rnd_xfer", int'($urandom % 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
